// File: rtl/round_key_store.sv
// Round-key store between AES key expansion and the round core; serves keys by round number.
// Optional ROUND_KEY_STORE_INVMIX_EN: decrypt reads of inner rounds return InvMixColumns(key).
module round_key_store (
    input  logic         clk,
    input  logic         rst,
    input  logic [1:0]   in_nk,
    input  logic         in_valid,
    input  logic         in_first_flag,
    input  logic         in_last_flag,
    input  logic [127:0] in_rk,
    input  logic         in_rd_en,
    input  logic [3:0]   in_rd_round,
    input  logic         in_rd_dec,
    output logic         out_ready,
    output logic         out_err,
    output logic [3:0]   out_nr,
    output logic         out_rd_valid,
    output logic [127:0] out_rd_rk
);

    // state   | meaning
    // S_EMPTY | no usable schedule
    // S_LOAD  | receiving keys, wr_cnt is the next slot
    // S_READY | Nr+1 keys stored, reads serviced
    typedef enum logic [1:0] {S_EMPTY, S_LOAD, S_READY} state_t;

    state_t       state, state_nxt;
    logic [3:0]   wr_cnt, wr_cnt_nxt;
    logic [3:0]   nr_nxt;
    logic         err_nxt;
    logic         wr_en;
    logic [3:0]   wr_idx;
    logic [127:0] slots [15];

    logic         rd_ok;
    logic [3:0]   rd_idx;
    logic [127:0] rd_key;
    logic [127:0] rd_data;

    function automatic logic [3:0] nr_from_nk(input logic [1:0] nk);
        case (nk)
            2'b01:   return 4'd12;
            2'b11:   return 4'd14;
            default: return 4'd10;
        endcase
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_EMPTY;
            wr_cnt  <= 4'd0;
            out_nr  <= 4'd10;
            out_err <= 1'b0;
        end else begin
            state   <= state_nxt;
            wr_cnt  <= wr_cnt_nxt;
            out_nr  <= nr_nxt;
            out_err <= err_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        wr_cnt_nxt = wr_cnt;
        nr_nxt     = out_nr;
        err_nxt    = out_err;
        wr_en      = 1'b0;
        wr_idx     = 4'd0;
        if (in_valid) begin
            if (in_first_flag) begin
                // A first-flagged word always restarts the schedule, whatever the state.
                wr_en      = 1'b1;
                wr_idx     = 4'd0;
                wr_cnt_nxt = 4'd1;
                nr_nxt     = nr_from_nk(in_nk);
                if (in_last_flag) begin
                    state_nxt = S_EMPTY;
                    err_nxt   = 1'b1;
                end else begin
                    state_nxt = S_LOAD;
                    err_nxt   = 1'b0;
                end
            end else if (state == S_LOAD) begin
                wr_en      = 1'b1;
                wr_idx     = wr_cnt;
                wr_cnt_nxt = wr_cnt + 4'd1;
                if (wr_cnt == out_nr) begin
                    if (in_last_flag) begin
                        state_nxt = S_READY;
                    end else begin
                        state_nxt = S_EMPTY;
                        err_nxt   = 1'b1;
                    end
                end else if (in_last_flag) begin
                    state_nxt = S_EMPTY;
                    err_nxt   = 1'b1;
                end
            end else begin
                err_nxt = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en && wr_idx != 4'd15) begin
            slots[wr_idx] <= in_rk;
        end
    end

    assign out_ready = (state == S_READY);

    assign rd_ok  = in_rd_en && (state == S_READY) && (in_rd_round <= out_nr);
    assign rd_idx = in_rd_dec ? (out_nr - in_rd_round) : in_rd_round;
    assign rd_key = (rd_idx != 4'd15) ? slots[rd_idx] : 128'd0;

`ifdef ROUND_KEY_STORE_INVMIX_EN
    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [31:0] inv_mix_col(input logic [31:0] c);
        logic [7:0] a [4];
        logic [7:0] m9 [4];
        logic [7:0] mb [4];
        logic [7:0] md [4];
        logic [7:0] me [4];
        logic [7:0] x2, x4, x8;
        for (int i = 0; i < 4; i++) begin
            a[i]  = c[31-8*i -: 8];
            x2    = xt(a[i]);
            x4    = xt(x2);
            x8    = xt(x4);
            m9[i] = x8 ^ a[i];
            mb[i] = x8 ^ x2 ^ a[i];
            md[i] = x8 ^ x4 ^ a[i];
            me[i] = x8 ^ x4 ^ x2;
        end
        return {me[0] ^ mb[1] ^ md[2] ^ m9[3],
                m9[0] ^ me[1] ^ mb[2] ^ md[3],
                md[0] ^ m9[1] ^ me[2] ^ mb[3],
                mb[0] ^ md[1] ^ m9[2] ^ me[3]};
    endfunction

    // Only inner decrypt rounds use the transformed key (equivalent inverse cipher).
    always_comb begin
        rd_data = rd_key;
        if (in_rd_dec && rd_idx != 4'd0 && rd_idx != out_nr) begin
            for (int c = 0; c < 4; c++) begin
                rd_data[127-32*c -: 32] = inv_mix_col(rd_key[127-32*c -: 32]);
            end
        end
    end
`else
    assign rd_data = rd_key;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            out_rd_valid <= 1'b0;
            out_rd_rk    <= 128'd0;
        end else begin
            out_rd_valid <= rd_ok;
            if (rd_ok) begin
                out_rd_rk <= rd_data;
            end
        end
    end

endmodule

// File: doc/round_key_store.md
# round_key_store

- Stores the round-key stream produced by the key-expansion stage: 11, 13 or 15 × 128-bit keys, marked by first/last flags.
- Serves keys to the cipher round datapath by round number, in forward (encrypt) or reversed (decrypt) order.
- Sits between key expansion and the AES round core, so one expansion serves any number of blocks.

## Interface
Parameters:
- none (capacity fixed at 15 keys × 128 bits)

Ports:
- clk  input  1  clock; all logic on rising edge
- rst  input  1  reset; synchronous, active-high
- in_nk  input  2  key size: 00→Nk4/Nr10, 01→Nk6/Nr12, 11→Nk8/Nr14; 10 treated as 00; sampled only on a first-flagged word
- in_valid  input  1  round key present on in_rk this cycle
- in_first_flag  input  1  key is round key 0
- in_last_flag  input  1  key is round key Nr
- in_rk  input  128  round key
- in_rd_en  input  1  read request
- in_rd_round  input  4  round number 0..Nr
- in_rd_dec  input  1  1 = decrypt order (slot Nr−round)
- out_ready  output  1  complete key schedule stored
- out_err  output  1  sticky schedule error; cleared by next first-flagged word or rst
- out_nr  output  4  Nr of stored/loading schedule (10/12/14)
- out_rd_valid  output  1  out_rd_rk valid this cycle
- out_rd_rk  output  128  read round key

## Operation
- Storage: 15 × 128-bit registers, slot index = key index; not reset.
- States:
  - EMPTY: no usable keys.
  - LOAD: receiving keys; wr_cnt = next slot.
  - READY: Nr+1 keys stored.
- Any state, in_valid & in_first_flag:
  - write slot 0; wr_cnt←1; latch Nr from in_nk into out_nr.
  - out_err←0; state→LOAD (restart even mid-load or when READY).
  - first & last both set: error path, →EMPTY with out_err←1.
- LOAD, in_valid, no first flag: write slot wr_cnt; wr_cnt+1.
  - wr_cnt==Nr with in_last_flag → READY.
  - wr_cnt==Nr without last, or in_last_flag with wr_cnt<Nr → word still written; state→EMPTY, out_err←1.
- EMPTY/READY, in_valid, no first flag:
  - word ignored, storage unchanged, out_err←1.
  - READY remains READY.
- out_ready = (state==READY).
- Reads:
  - idx = in_rd_dec ? out_nr−in_rd_round : in_rd_round (4-bit).
  - Serviced only if state==READY and in_rd_round ≤ out_nr in the request cycle.
  - Otherwise out_rd_valid=0 next cycle and out_rd_rk holds.

## Timing
- Reset values:
  - state EMPTY, wr_cnt 0, out_nr 10.
  - out_ready 0, out_err 0, out_rd_valid 0, out_rd_rk 0.
- Write: key stored at the edge where in_valid=1; out_ready rises the cycle after the last-flagged key.
- Read latency 1: request in cycle t → out_rd_valid=1, out_rd_rk in cycle t+1. out_rd_valid is a single-cycle pulse per request; back-to-back reads every cycle.
- No backpressure on the write side: every in_valid must be accepted.
- Read and first-flagged write in the same cycle: the read is serviced from pre-edge contents (old slot 0 / old schedule); out_ready drops the next cycle.
- Read of slot k in the same cycle as its write in LOAD: not serviced (state≠READY).
- rst asserted mid-load or mid-read: all outputs take reset values next cycle; any pending read is dropped.

## Configuration
- Macro: ROUND_KEY_STORE_INVMIX_EN.
- Defined:
  - decrypt reads (in_rd_dec=1) of idx 1..Nr−1 return InvMixColumns(stored key), per column, GF(2^8) modulus 0x11B.
  - Supports the equivalent inverse cipher.
  - Idx 0 and Nr are returned unmodified; latency stays 1 (transform on the read path before the output register).
- Undefined: all reads return stored keys unmodified; no InvMixColumns logic.

## Test plan
- Nk4 load of 11 keys (key i = {32{4'hi}} pattern) → out_ready=1 one cycle after key 10, out_nr=10, out_err=0; forward read of rounds 0..10 → each key one cycle later, back-to-back.
- Nk8 load of 15 keys, in_rd_dec=1, round 0 → slot 14 key.
  - Macro undefined: round 1 → slot 13 key unmodified.
  - Macro defined: round 1 → InvMixColumns(slot 13); round 14 → slot 0 unmodified.
- Nk6 load with last flag on key 11 → state EMPTY, out_err=1, out_ready=0.
  - Reads return out_rd_valid=0.
  - A new first-flagged load clears out_err.
- READY (Nr=10), read round 11 → out_rd_valid=0, out_rd_rk unchanged.
  - Stray non-first in_valid → out_err=1, out_ready stays 1.
- READY, read round 0 in the same cycle as a new first-flagged key → out_rd_rk = old slot 0, then out_ready=0.
- rst during LOAD after 5 keys → next cycle all outputs at reset values; full reload then succeeds.
